// File: rtl/sdram_user_responder_pkg.sv
// Shared types and constants for the SDRAM user-port responder.
// State encoding, write-mask polarity and counter sizing live here.
package sdram_user_responder_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_ACC  = 2'd2,
    ST_REF  = 2'd3
  } state_e;

  // Host mask bits are 0 for lanes that must be written.
  localparam bit MASK_ACTIVE_LOW = 1'b1;

  function automatic logic [3:0] lane_enables(input logic [3:0] mask);
    return MASK_ACTIVE_LOW ? ~mask : mask;
  endfunction

  // Bits needed to hold max(a,b)-1 in the busy down-counter.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sdram_user_responder_bram_be_sp.sv
// Single-port 32-bit RAM with four byte-lane write enables and a
// one-cycle registered read (read-first on simultaneous access).
module bram_be_sp #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_user_responder.sv
// Slave end of the read/write/refresh + busy handshake, backed by on-chip
// byte-enabled RAM instead of external SDRAM.
module sdram_user_responder
  import sdram_user_responder_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int LATENCY        = 4,
  parameter int REFRESH_CYCLES = 8,
  parameter bit INIT_CLEAR     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic        read_a,
  input  logic        read_b,
  input  logic        write,
  input  logic        refresh,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  mask,
  output logic [31:0] dout_a,
  output logic        busy,
  output logic        mem_initialized,
  output logic [31:0] total_written
);

  localparam int CNT_W = cnt_width(LATENCY, REFRESH_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   init_idx_q, init_idx_d;
  logic [ADDR_W-1:0]   widx_q, widx_d;
  logic [31:0]         din_q, din_d;
  logic [3:0]          mask_q, mask_d;
  logic                is_wr_q, is_wr_d;
  logic [31:0]         dout_q, dout_d;
  logic [31:0]         total_q, total_d;
  logic                init_done_q, init_done_d;

  logic                ram_en;
  logic [3:0]          ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [31:0]         ram_wdata;
  logic [31:0]         ram_rdata;

  logic                unused_inputs;
  assign unused_inputs = ^{read_b, addr[31:ADDR_W+2], addr[1:0]};

  bram_be_sp #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      init_idx_q  <= '0;
      widx_q      <= '0;
      din_q       <= '0;
      mask_q      <= '1;
      is_wr_q     <= 1'b0;
      dout_q      <= '0;
      total_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      widx_q      <= widx_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      is_wr_q     <= is_wr_d;
      dout_q      <= dout_d;
      total_q     <= total_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    widx_d      = widx_q;
    din_d       = din_q;
    mask_d      = mask_q;
    is_wr_d     = is_wr_q;
    dout_d      = dout_q;
    total_d     = total_q;
    init_done_d = init_done_q;
    ram_en      = 1'b0;
    ram_we      = 4'h0;
    ram_addr    = widx_q;
    ram_wdata   = din_q;

    case (state_q)
      ST_INIT: begin
        if (INIT_CLEAR) begin
          ram_en     = 1'b1;
          ram_we     = 4'hF;
          ram_addr   = init_idx_q;
          ram_wdata  = '0;
          init_idx_d = init_idx_q + 1'b1;
          if (init_idx_q == '1) begin
            state_d     = ST_IDLE;
            init_done_d = 1'b1;
          end
        end else begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (write) begin
          widx_d  = addr[ADDR_W+1:2];
          din_d   = din;
          mask_d  = mask;
          is_wr_d = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_ACC;
        end else if (read_a) begin
          widx_d  = addr[ADDR_W+1:2];
          is_wr_d = 1'b0;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_ACC;
        end else if (refresh) begin
          cnt_d   = CNT_W'(REFRESH_CYCLES - 1);
          state_d = ST_REF;
        end
      end
      ST_ACC: begin
        // The RAM access goes out on the first busy cycle; LATENCY>=2 leaves
        // the registered read settled well before the final edge.
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          ram_en = 1'b1;
          if (is_wr_q) begin
            ram_we  = lane_enables(mask_q);
            total_d = total_q + 32'd1;
          end
        end
        if (cnt_q == '0) begin
          if (!is_wr_q) dout_d = ram_rdata;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_REF: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign busy            = (state_q != ST_IDLE);
  assign mem_initialized = init_done_q;
  assign dout_a          = dout_q;
  assign total_written   = total_q;

endmodule

// File: tb/tb_sdram_user_responder.sv
// Randomized self-checking bench for sdram_user_responder against a
// word-array reference model (16-word configuration).
module tb_sdram_user_responder;

  localparam int AW   = 4;
  localparam int LAT  = 4;
  localparam int REFC = 8;
  localparam int NW   = 2**AW;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        read_a, read_b, write, refresh;
  logic [31:0] addr, din;
  logic [3:0]  mask;
  logic [31:0] dout_a;
  logic        busy;
  logic        mem_initialized;
  logic [31:0] total_written;

  int          checks = 0;
  int          passed = 0;

  logic [31:0] mdl_mem [NW];
  logic [31:0] mdl_dout;
  logic [31:0] mdl_total;

  sdram_user_responder #(
    .ADDR_W(AW), .LATENCY(LAT), .REFRESH_CYCLES(REFC), .INIT_CLEAR(1'b1)
  ) dut (
    .clk(clk), .rst_x(rst_x), .read_a(read_a), .read_b(read_b), .write(write),
    .refresh(refresh), .addr(addr), .din(din), .mask(mask), .dout_a(dout_a),
    .busy(busy), .mem_initialized(mem_initialized), .total_written(total_written)
  );

  always #5 clk = ~clk;

  function automatic int widx(input logic [31:0] a);
    return int'(a / 4) % NW;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    for (int b = 0; b < 4; b++)
      if (!m[b]) mdl_mem[widx(a)][b*8 +: 8] = d[b*8 +: 8];
    mdl_total = mdl_total + 1;
  endtask

  // Issue one command; hold it `hold` busy cycles, return busy length.
  task automatic run_cmd(input bit w, input bit r, input bit f, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input int hold,
                         output int nbusy);
    write = w; read_a = r; refresh = f; addr = a; din = d; mask = m;
    nbusy = 0;
    @(negedge clk);
    for (int i = 0; i < 200; i++) begin
      if (i == hold) begin write = 0; read_a = 0; refresh = 0; end
      if (busy) nbusy++;
      else break;
      @(negedge clk);
    end
    write = 0; read_a = 0; refresh = 0;
  endtask

  task automatic test_reset();
    int n;
    rst_x = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) $display("FAIL rst_busy got %0h expected 1", busy); else passed++;
    checks++; if (mem_initialized !== 1'b0) $display("FAIL rst_meminit got %0h expected 0", mem_initialized); else passed++;
    checks++; if (dout_a !== 32'h0) $display("FAIL rst_dout got %08h expected 00000000", dout_a); else passed++;
    checks++; if (total_written !== 32'h0) $display("FAIL rst_total got %0d expected 0", total_written); else passed++;
    for (int i = 0; i < NW; i++) mdl_mem[i] = 32'h0;
    mdl_dout = 32'h0; mdl_total = 32'h0;
    @(negedge clk);
    rst_x = 1'b1;
    #1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b1 && mem_initialized === 1'b0) n++;
      else break;
      @(negedge clk);
    end
    checks++; if (n != NW) $display("FAIL init_cycles got %0d expected %0d", n, NW); else passed++;
    checks++; if (busy !== 1'b0 || mem_initialized !== 1'b1)
      $display("FAIL init_done got busy=%0h init=%0h expected busy=0 init=1", busy, mem_initialized); else passed++;
    $display("reset/init: %0d init cycles", n);
  endtask

  task automatic test_init_zero();
    int nb;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      a = $urandom;
      run_cmd(0, 1, 0, a, 32'h0, 4'h0, 0, nb);
      mdl_dout = mdl_mem[widx(a)];
      checks++; if (nb != LAT) $display("FAIL zero_busy got %0d expected %0d", nb, LAT); else passed++;
      checks++; if (dout_a !== 32'h0) $display("FAIL zero_read got %08h expected 00000000", dout_a); else passed++;
      $display("init read addr=%08h dout=%08h", a, dout_a);
    end
  endtask

  task automatic test_full_word();
    int nb;
    run_cmd(1, 0, 0, 32'h40, 32'hDEADBEEF, 4'h0, 0, nb);
    model_write(32'h40, 32'hDEADBEEF, 4'h0);
    checks++; if (nb != LAT) $display("FAIL fw_busy got %0d expected %0d", nb, LAT); else passed++;
    checks++; if (total_written !== 32'd1) $display("FAIL fw_total got %0d expected 1", total_written); else passed++;
    run_cmd(0, 1, 0, 32'h40, 32'h0, 4'h0, 0, nb);
    mdl_dout = mdl_mem[widx(32'h40)];
    checks++; if (dout_a !== 32'hDEADBEEF) $display("FAIL fw_read got %08h expected deadbeef", dout_a); else passed++;
    $display("full word: busy=%0d dout=%08h total=%0d", nb, dout_a, total_written);
  endtask

  task automatic test_byte_mask();
    int nb;
    run_cmd(1, 0, 0, 32'h40, 32'h00AA0000, 4'b1011, 0, nb);
    model_write(32'h40, 32'h00AA0000, 4'b1011);
    run_cmd(0, 1, 0, 32'h40, 32'h0, 4'h0, 0, nb);
    mdl_dout = mdl_mem[widx(32'h40)];
    checks++; if (dout_a !== 32'hDEAABEEF) $display("FAIL mask_read got %08h expected deaabeef", dout_a); else passed++;
    $display("byte mask: dout=%08h", dout_a);
  endtask

  task automatic test_handshake();
    int nb, n, extra;
    run_cmd(0, 1, 0, 32'h40, 32'h0, 4'h0, 1, nb);
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy) extra++;
    end
    checks++; if (nb != LAT || extra != 0)
      $display("FAIL hs_single got busy=%0d extra=%0d expected busy=%0d extra=0", nb, extra, LAT); else passed++;
    addr = 32'h40; read_a = 1'b1;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 50 && busy; i++) begin n++; @(negedge clk); end
    checks++; if (n != LAT) $display("FAIL hs_first got %0d expected %0d", n, LAT); else passed++;
    @(negedge clk);
    read_a = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL hs_second_start got %0h expected 1", busy); else passed++;
    nb = 0;
    for (int i = 0; i < 50 && busy; i++) begin nb++; @(negedge clk); end
    checks++; if (nb != LAT) $display("FAIL hs_second_busy got %0d expected %0d", nb, LAT); else passed++;
    checks++; if (dout_a !== mdl_dout) $display("FAIL hs_dout got %08h expected %08h", dout_a, mdl_dout); else passed++;
    $display("handshake: first=%0d second=%0d dout=%08h", n, nb, dout_a);
  endtask

  task automatic test_priority();
    int nb;
    logic [31:0] a, d;
    a = $urandom; d = $urandom;
    run_cmd(1, 1, 1, a, d, 4'h0, 0, nb);
    model_write(a, d, 4'h0);
    checks++; if (nb != LAT) $display("FAIL prio_busy got %0d expected %0d", nb, LAT); else passed++;
    checks++; if (total_written !== mdl_total) $display("FAIL prio_total got %0d expected %0d", total_written, mdl_total); else passed++;
    checks++; if (dout_a !== mdl_dout) $display("FAIL prio_dout got %08h expected %08h", dout_a, mdl_dout); else passed++;
    run_cmd(0, 1, 0, a, 32'h0, 4'h0, 0, nb);
    mdl_dout = mdl_mem[widx(a)];
    checks++; if (dout_a !== mdl_dout) $display("FAIL prio_read got %08h expected %08h", dout_a, mdl_dout); else passed++;
    $display("priority: addr=%08h busy=%0d total=%0d", a, nb, total_written);
  endtask

  task automatic test_refresh();
    int nb;
    run_cmd(0, 0, 1, 32'h0, 32'h0, 4'h0, 0, nb);
    checks++; if (nb != REFC) $display("FAIL ref_busy got %0d expected %0d", nb, REFC); else passed++;
    checks++; if (dout_a !== mdl_dout) $display("FAIL ref_dout got %08h expected %08h", dout_a, mdl_dout); else passed++;
    $display("refresh: busy=%0d dout=%08h", nb, dout_a);
  endtask

  task automatic test_random();
    int nb, k;
    logic [31:0] a, d;
    logic [3:0]  m;
    for (int t = 0; t < 40; t++) begin
      k = $urandom_range(0, 2);
      a = $urandom; d = $urandom; m = 4'($urandom);
      run_cmd(k == 0, k == 1, k == 2, a, d, m, 0, nb);
      if (k == 0) model_write(a, d, m);
      if (k == 1) mdl_dout = mdl_mem[widx(a)];
      checks++; if (nb != ((k == 2) ? REFC : LAT))
        $display("FAIL rnd_busy[%0d] got %0d expected %0d", t, nb, (k == 2) ? REFC : LAT); else passed++;
      checks++; if (dout_a !== mdl_dout) $display("FAIL rnd_dout[%0d] got %08h expected %08h", t, dout_a, mdl_dout); else passed++;
      checks++; if (total_written !== mdl_total)
        $display("FAIL rnd_total[%0d] got %0d expected %0d", t, total_written, mdl_total); else passed++;
      $display("rnd %0d kind=%0d addr=%08h din=%08h mask=%h dout=%08h total=%0d", t, k, a, d, m, dout_a, total_written);
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    logic [31:0] a;
    a = 32'h40;
    write = 1'b1; addr = a; din = 32'h12345678; mask = 4'h0;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    test_reset();
    checks++; if (total_written !== 32'h0) $display("FAIL mid_total got %0d expected 0", total_written); else passed++;
    run_cmd(0, 1, 0, a, 32'h0, 4'h0, 0, nb);
    mdl_dout = mdl_mem[widx(a)];
    checks++; if (dout_a !== 32'h0) $display("FAIL mid_recleared got %08h expected 00000000", dout_a); else passed++;
    $display("reset mid-ACC: dout=%08h total=%0d", dout_a, total_written);
  endtask

  initial begin
    rst_x = 1'b0; read_a = 0; read_b = 0; write = 0; refresh = 0;
    addr = 0; din = 0; mask = 4'hF;
    @(negedge clk);
    test_reset();
    test_init_zero();
    test_full_word();
    test_byte_mask();
    test_handshake();
    test_priority();
    test_refresh();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
